// File: rtl/i2c_aux_pkg.sv
// rtl/i2c_aux_pkg.sv - shared I2C-over-AUX reply codes, request types and responder states
// Purpose: common enums for the AUX responder and initiator.
//   reply_t : AUX reply codes (ACK/NACK/DEFER).
//   req_t   : decoded request types from the AUX request decoder.
//   rsp_state_t : responder FSM states.
package i2c_aux_pkg;

    typedef enum logic [1:0] {
        RPL_ACK   = 2'b00,
        RPL_NACK  = 2'b01,
        RPL_DEFER = 2'b10
    } reply_t;

    typedef enum logic [1:0] {
        REQ_ADDR = 2'b00,
        REQ_DATA = 2'b01,
        REQ_END  = 2'b10,
        REQ_RSVD = 2'b11
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FETCH  = 2'b10,
        ST_REPLY  = 2'b11
    } rsp_state_t;

endpackage

// File: rtl/i2c_aux_rsp_timer.sv
// rtl/i2c_aux_rsp_timer.sv - loadable down-counter for reply turnaround and defer waits
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : load strobe (wins over counting)
//   load     : count value captured on start
//   done     : high for one cycle, load cycles after the start edge
module i2c_aux_rsp_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= load;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/i2c_aux_responder.sv
// rtl/i2c_aux_responder.sv - sink-side I2C-over-AUX EDID read responder
// Optional feature macro: I2C_AUX_RSP_DEFER_EN (DEFER after DEFER_WAIT cycles in FETCH).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_vld/req_type/req_addr     : request strobe from the AUX request decoder
//   edid_rdy/edid_data            : EDID store read response
//   edid_rd_en/edid_rd_addr       : EDID store read request
//   reply_ack/reply_ack_vld       : reply code and strobe to the reply encoder
//   reply_data/reply_data_vld     : read byte and strobe for DATA ACKs
//   xfer_done                     : pulse with an END ACK
//   busy                          : high in FETCH and REPLY
//   req_drop                      : pulse when a request arrives in FETCH or REPLY
module i2c_aux_responder
    import i2c_aux_pkg::*;
#(
    parameter int         EDID_SIZE   = 5,
    parameter logic [6:0] I2C_ADDR    = 7'h50,
    parameter int         REPLY_DELAY = 4,
    parameter int         DEFER_WAIT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    input  logic [1:0] req_type,
    input  logic [6:0] req_addr,
    input  logic       edid_rdy,
    input  logic [7:0] edid_data,
    output logic       edid_rd_en,
    output logic [7:0] edid_rd_addr,
    output logic [1:0] reply_ack,
    output logic       reply_ack_vld,
    output logic [7:0] reply_data,
    output logic       reply_data_vld,
    output logic       xfer_done,
    output logic       busy,
    output logic       req_drop
);

    localparam int            CW         = $clog2(EDID_SIZE + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(EDID_SIZE);
    // The timer fires load cycles after its start edge; one extra cycle puts
    // the strobe REPLY_DELAY+1 edges after the decision.
    localparam logic [7:0]    REPLY_LOAD = 8'(REPLY_DELAY + 1);
`ifdef I2C_AUX_RSP_DEFER_EN
    localparam logic [7:0]    DEFER_LOAD = 8'(DEFER_WAIT);
`endif

    if (REPLY_DELAY < 1 || REPLY_DELAY > 15) begin : g_bad_reply_delay
        $error("REPLY_DELAY must be in 1..15");
    end
    if (DEFER_WAIT < 1 || DEFER_WAIT > 255) begin : g_bad_defer_wait
        $error("DEFER_WAIT must be in 1..255");
    end

    rsp_state_t    state, state_nxt;
    rsp_state_t    ret, ret_nxt;
    logic [CW-1:0] byte_cnt, byte_cnt_nxt;
    reply_t        code, code_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          is_data, is_data_nxt;
    logic          is_end, is_end_nxt;
    // 0: FETCH entry cycle, 1: read strobe cycle, 2: waiting for data
    logic [1:0]    fetch_ph, fetch_ph_nxt;
    logic          tmr_start;
    logic [7:0]    tmr_load;
    logic          tmr_done;
    req_t          rtype;

    assign rtype        = req_t'(req_type);
    assign edid_rd_addr = 8'(byte_cnt);
    assign reply_ack    = code;
    assign reply_data   = data_q;

    i2c_aux_rsp_timer #(.W(8)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tmr_start),
        .load  (tmr_load),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ret      <= ST_IDLE;
            byte_cnt <= '0;
            code     <= RPL_ACK;
            data_q   <= 8'h00;
            is_data  <= 1'b0;
            is_end   <= 1'b0;
            fetch_ph <= 2'd0;
        end else begin
            state    <= state_nxt;
            ret      <= ret_nxt;
            byte_cnt <= byte_cnt_nxt;
            code     <= code_nxt;
            data_q   <= data_nxt;
            is_data  <= is_data_nxt;
            is_end   <= is_end_nxt;
            fetch_ph <= fetch_ph_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ret_nxt        = ret;
        byte_cnt_nxt   = byte_cnt;
        code_nxt       = code;
        data_nxt       = data_q;
        is_data_nxt    = is_data;
        is_end_nxt     = is_end;
        fetch_ph_nxt   = fetch_ph;
        tmr_start      = 1'b0;
        tmr_load       = REPLY_LOAD;
        edid_rd_en     = 1'b0;
        reply_ack_vld  = 1'b0;
        reply_data_vld = 1'b0;
        xfer_done      = 1'b0;
        busy           = 1'b0;
        req_drop       = 1'b0;

        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (req_vld) begin
                    // Default decision: NACK and come back to where we were.
                    state_nxt   = ST_REPLY;
                    ret_nxt     = state;
                    code_nxt    = RPL_NACK;
                    is_data_nxt = 1'b0;
                    is_end_nxt  = 1'b0;
                    tmr_start   = 1'b1;
                    case (rtype)
                        REQ_ADDR: begin
                            if (req_addr == I2C_ADDR) begin
                                code_nxt     = RPL_ACK;
                                ret_nxt      = ST_ACTIVE;
                                byte_cnt_nxt = '0;
                            end else begin
                                ret_nxt = ST_IDLE;
                            end
                        end
                        REQ_DATA: begin
                            if (state == ST_ACTIVE && byte_cnt < CNT_MAX) begin
                                state_nxt    = ST_FETCH;
                                fetch_ph_nxt = 2'd0;
`ifdef I2C_AUX_RSP_DEFER_EN
                                tmr_start    = 1'b1;
                                tmr_load     = DEFER_LOAD;
`else
                                tmr_start    = 1'b0;
`endif
                            end
                        end
                        REQ_END: begin
                            if (state == ST_ACTIVE) begin
                                code_nxt   = RPL_ACK;
                                is_end_nxt = 1'b1;
                                ret_nxt    = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_FETCH: begin
                busy       = 1'b1;
                req_drop   = req_vld;
                edid_rd_en = (fetch_ph == 2'd1);
                if (fetch_ph != 2'd2) begin
                    fetch_ph_nxt = fetch_ph + 2'd1;
                end
                if (fetch_ph != 2'd0) begin
                    // Data is checked before the timeout so a same-edge
                    // arrival is still ACKed.
                    if (edid_rdy) begin
                        state_nxt   = ST_REPLY;
                        ret_nxt     = ST_ACTIVE;
                        code_nxt    = RPL_ACK;
                        data_nxt    = edid_data;
                        is_data_nxt = 1'b1;
                        is_end_nxt  = 1'b0;
                        tmr_start   = 1'b1;
                        if (byte_cnt != CNT_MAX) begin
                            byte_cnt_nxt = byte_cnt + CW'(1);
                        end
                    end
`ifdef I2C_AUX_RSP_DEFER_EN
                    else if (tmr_done) begin
                        state_nxt   = ST_REPLY;
                        ret_nxt     = ST_ACTIVE;
                        code_nxt    = RPL_DEFER;
                        is_data_nxt = 1'b0;
                        is_end_nxt  = 1'b0;
                        tmr_start   = 1'b1;
                    end
`endif
                end
            end

            ST_REPLY: begin
                busy     = 1'b1;
                req_drop = req_vld;
                // The strobe cycle is still REPLY, so a coincident request drops.
                if (tmr_done) begin
                    reply_ack_vld  = 1'b1;
                    reply_data_vld = is_data;
                    xfer_done      = is_end;
                    state_nxt      = ret;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
